ofs_fim_pcie_ss_sb_tlp_arb: RTL and testbench
=============================================

// Module: ofs_fim_pcie_ss_sb_tlp_arb
//
// PURPOSE
//  Packet-boundary round-robin arbiter for side-band-header PCIe SS AXI-S streams.
//  Merges NUM_SRC streams into one; a TLP (SOP beat .. tlast beat) is never interleaved.
//  Sits after ofs_fim_pcie_ss_ib2sb instances, ahead of the shared TX/host channel.
//  Output is one registered stage.
//
// PARAMETERS
//  NUM_SRC    4    number of input streams (2..16)
//  DATA_W     512  tdata width; tkeep is DATA_W/8
//  USER_W     257  tuser_vendor width ({hdr[255:0], vendor bit})
//  SRC_W      $clog2(NUM_SRC)  source-id width (derived localparam)
//
// PORTS
//  clk             in   1                 clock
//  rst_n           in   1                 async active-low reset
//  in_tvalid       in   NUM_SRC           per-source valid
//  in_tready       out  NUM_SRC           per-source ready
//  in_tdata        in   NUM_SRC*DATA_W    per-source data
//  in_tkeep        in   NUM_SRC*DATA_W/8  per-source keep
//  in_tlast        in   NUM_SRC           per-source end-of-TLP
//  in_tuser_vendor in   NUM_SRC*USER_W    per-source side-band user/header
//  out_tvalid      out  1                 merged valid (registered)
//  out_tready      in   1                 merged ready
//  out_tdata       out  DATA_W            merged data
//  out_tkeep       out  DATA_W/8          merged keep
//  out_tlast       out  1                 merged end-of-TLP
//  out_tuser_vendor out USER_W            merged user/header
//  out_src_id      out  SRC_W             source index of current beat
//
// BEHAVIOUR
//  - Reset (async assert, sync release): out_tvalid=0, out_* data=0, out_src_id=0,
//    state=IDLE, rr_ptr=0, in_tready=0.
//  - adv = !out_tvalid || out_tready; in_tready[i] = adv && grant[i].
//  - States: IDLE, LOCKED(owner).
//    IDLE: grant = first i with in_tvalid[i], searching from rr_ptr upward with wrap.
//    Accepted beat with tlast=0 -> LOCKED(owner=i). Accepted beat with tlast=1 ->
//    stay IDLE, rr_ptr=i+1 mod NUM_SRC.
//    LOCKED: grant only owner; other valids ignored. Owner tlast beat accepted -> IDLE,
//    rr_ptr=owner+1 mod NUM_SRC.
//  - Latency: accepted input beat appears on out_* the next cycle; full throughput
//    (1 beat/cycle) while out_tready=1. No bubble between back-to-back TLPs.
//  - Output register loads on adv; holds all fields stable while out_tvalid && !out_tready.
//    out_tvalid clears on adv with no accepted beat.
//  - Owner deasserting in_tvalid mid-TLP: arbiter stays LOCKED (bubble), no switch.
//  - No valid inputs in IDLE: rr_ptr unchanged.
//  - Reset mid-TLP: lock dropped, in-flight output beat discarded; sources must
//    restart from a TLP boundary.
//  - tuser_vendor passed unmodified every beat; header meaningful on SOP beat only.
//
// CONFIGURATION
//  OFS_PCIE_SS_ARB_SRC0_PRIO_EN defined: in IDLE, source 0 wins whenever
//  in_tvalid[0]=1 (strict priority); remaining sources are round-robin as above,
//  and rr_ptr is not updated on source-0 grants. Locking rules unchanged.
//  Undefined: pure round-robin for all sources.
//
// TESTING
//  1. All 4 sources valid, 1-beat TLPs, out_tready=1 -> out_src_id 0,1,2,3,0,...
//     one beat/cycle.
//  2. Src1 sends 5-beat TLP, src2 valid throughout -> 5 contiguous src1 beats,
//     then src2; src2 in_tready=0 during lock.
//  3. out_tready=0 for 3 cycles mid-TLP -> out_* stable, no beat lost or duplicated.
//  4. Owner in_tvalid drops 2 cycles mid-TLP -> 2-cycle output bubble, no switch.
//  5. rst_n asserted during src3 beat 2 of 4 -> out_tvalid=0 immediately; after
//     release, rr_ptr=0 and src0 granted first.
//  6. Random 10000 TLPs, random backpressure (1/16 stall), with and without
//     OFS_PCIE_SS_ARB_SRC0_PRIO_EN -> per-source TLP order and content match
//     reference queues; source 0 always wins from IDLE when prio is enabled.

Source files
------------

// File: rtl/ofs_fim_pcie_ss_sb_tlp_arb.sv
// ofs_fim_pcie_ss_sb_tlp_arb
// Packet-boundary round-robin arbiter for side-band-header PCIe SS AXI-S
// streams. NUM_SRC inputs are merged into one registered output stream.
// A TLP (SOP beat through tlast beat) from one source is never interleaved
// with beats from another source.
//
// Optional feature macro: OFS_PCIE_SS_ARB_SRC0_PRIO_EN
//   When defined, source 0 wins every new-TLP arbitration in which it is
//   valid, and its grants leave the round-robin pointer untouched. The
//   locking rules stay the same. When undefined, all sources are pure
//   round-robin.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | at a TLP boundary; the next TLP's source is picked here
// ST_LOCKED | mid-TLP; only owner_q is granted until its tlast beat

module ofs_fim_pcie_ss_sb_tlp_arb #(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 512,
    parameter int USER_W  = 257
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_SRC-1:0]          in_tvalid,
    output logic [NUM_SRC-1:0]          in_tready,
    input  logic [NUM_SRC*DATA_W-1:0]   in_tdata,
    input  logic [NUM_SRC*DATA_W/8-1:0] in_tkeep,
    input  logic [NUM_SRC-1:0]          in_tlast,
    input  logic [NUM_SRC*USER_W-1:0]   in_tuser_vendor,
    output logic                        out_tvalid,
    input  logic                        out_tready,
    output logic [DATA_W-1:0]           out_tdata,
    output logic [DATA_W/8-1:0]         out_tkeep,
    output logic                        out_tlast,
    output logic [USER_W-1:0]           out_tuser_vendor,
    output logic [$clog2(NUM_SRC)-1:0]  out_src_id
);

    localparam int SRC_W  = $clog2(NUM_SRC);
    localparam int KEEP_W = DATA_W / 8;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [SRC_W-1:0]    owner_q, owner_d;
    logic [SRC_W-1:0]    rr_ptr_q, rr_ptr_d;

    logic                out_tvalid_q;
    logic [DATA_W-1:0]   out_tdata_q;
    logic [KEEP_W-1:0]   out_tkeep_q;
    logic                out_tlast_q;
    logic [USER_W-1:0]   out_tuser_q;
    logic [SRC_W-1:0]    out_src_id_q;

    logic [SRC_W-1:0]    rr_idx;
    logic                rr_vld;
    logic [SRC_W:0]      rr_sum;

    logic [SRC_W-1:0]    grant_idx;
    logic                grant_vld;
    logic [SRC_W-1:0]    grant_inc;
    logic                adv;
    logic                accept;

    logic [DATA_W-1:0]   sel_tdata;
    logic [KEEP_W-1:0]   sel_tkeep;
    logic                sel_tlast;
    logic [USER_W-1:0]   sel_tuser;

    // The output stage can take a new beat when empty or being drained.
    assign adv = !out_tvalid_q || out_tready;

    // Round-robin search: first valid source at or above rr_ptr_q, with wrap.
    // Scanning from the far end down lets the nearest hit win without a break.
    always_comb begin
        rr_idx = '0;
        rr_vld = 1'b0;
        rr_sum = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            rr_sum = {1'b0, rr_ptr_q} + (SRC_W+1)'(k);
            if (rr_sum >= (SRC_W+1)'(NUM_SRC)) begin
                rr_sum = rr_sum - (SRC_W+1)'(NUM_SRC);
            end
            if (in_tvalid[rr_sum[SRC_W-1:0]]) begin
                rr_idx = rr_sum[SRC_W-1:0];
                rr_vld = 1'b1;
            end
        end
    end

    // Grant selection: owner while locked, arbitration result at a boundary.
    always_comb begin
        grant_idx = owner_q;
        grant_vld = 1'b1;
        if (state_q == ST_IDLE) begin
            grant_idx = rr_idx;
            grant_vld = rr_vld;
`ifdef OFS_PCIE_SS_ARB_SRC0_PRIO_EN
            if (in_tvalid[0]) begin
                grant_idx = '0;
                grant_vld = 1'b1;
            end
`endif
        end
    end

    // Per-source ready; held low while reset is asserted.
    always_comb begin
        in_tready = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            in_tready[i] = rst_n && adv && grant_vld && (grant_idx == SRC_W'(i));
        end
    end

    assign accept = rst_n && adv && grant_vld && in_tvalid[grant_idx];

    // Payload mux for the granted source.
    always_comb begin
        sel_tdata = '0;
        sel_tkeep = '0;
        sel_tlast = 1'b0;
        sel_tuser = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_idx == SRC_W'(i)) begin
                sel_tdata = in_tdata[i*DATA_W +: DATA_W];
                sel_tkeep = in_tkeep[i*KEEP_W +: KEEP_W];
                sel_tlast = in_tlast[i];
                sel_tuser = in_tuser_vendor[i*USER_W +: USER_W];
            end
        end
    end

    assign grant_inc = (grant_idx == SRC_W'(NUM_SRC - 1)) ? '0 : grant_idx + SRC_W'(1);

    // Next lock state and pointer; the pointer only moves at a TLP end.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            if (sel_tlast) begin
                state_d = ST_IDLE;
`ifdef OFS_PCIE_SS_ARB_SRC0_PRIO_EN
                if (grant_idx != '0) begin
                    rr_ptr_d = grant_inc;
                end
`else
                rr_ptr_d = grant_inc;
`endif
            end else begin
                state_d = ST_LOCKED;
                owner_d = grant_idx;
            end
        end
    end

    // Lock state, round-robin pointer and the registered output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            rr_ptr_q     <= '0;
            out_tvalid_q <= 1'b0;
            out_tdata_q  <= '0;
            out_tkeep_q  <= '0;
            out_tlast_q  <= 1'b0;
            out_tuser_q  <= '0;
            out_src_id_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            if (adv) begin
                out_tvalid_q <= accept;
                if (accept) begin
                    out_tdata_q  <= sel_tdata;
                    out_tkeep_q  <= sel_tkeep;
                    out_tlast_q  <= sel_tlast;
                    out_tuser_q  <= sel_tuser;
                    out_src_id_q <= grant_idx;
                end
            end
        end
    end

    assign out_tvalid       = out_tvalid_q;
    assign out_tdata        = out_tdata_q;
    assign out_tkeep        = out_tkeep_q;
    assign out_tlast        = out_tlast_q;
    assign out_tuser_vendor = out_tuser_q;
    assign out_src_id       = out_src_id_q;

endmodule

// File: tb/tb_ofs_fim_pcie_ss_sb_tlp_arb.sv
// Testbench for ofs_fim_pcie_ss_sb_tlp_arb: random per-source TLP streams
// checked against a TLP-level arbitration model and a one-beat output model.
module tb_ofs_fim_pcie_ss_sb_tlp_arb;

    localparam int NUM_SRC = 4;
    localparam int DATA_W  = 512;
    localparam int USER_W  = 257;
    localparam int KEEP_W  = DATA_W / 8;
    localparam int SRC_W   = 2;

`ifdef OFS_PCIE_SS_ARB_SRC0_PRIO_EN
    localparam bit PRIO_EN = 1'b1;
`else
    localparam bit PRIO_EN = 1'b0;
`endif

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b0;
    logic [NUM_SRC-1:0]          in_tvalid = '0;
    logic [NUM_SRC-1:0]          in_tready;
    logic [NUM_SRC*DATA_W-1:0]   in_tdata = '0;
    logic [NUM_SRC*KEEP_W-1:0]   in_tkeep = '0;
    logic [NUM_SRC-1:0]          in_tlast = '0;
    logic [NUM_SRC*USER_W-1:0]   in_tuser_vendor = '0;
    logic                        out_tvalid;
    logic                        out_tready = 1'b0;
    logic [DATA_W-1:0]           out_tdata;
    logic [KEEP_W-1:0]           out_tkeep;
    logic                        out_tlast;
    logic [USER_W-1:0]           out_tuser_vendor;
    logic [SRC_W-1:0]            out_src_id;

    always #5 clk = ~clk;

    ofs_fim_pcie_ss_sb_tlp_arb #(
        .NUM_SRC (NUM_SRC),
        .DATA_W  (DATA_W),
        .USER_W  (USER_W)
    ) u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_tvalid        (in_tvalid),
        .in_tready        (in_tready),
        .in_tdata         (in_tdata),
        .in_tkeep         (in_tkeep),
        .in_tlast         (in_tlast),
        .in_tuser_vendor  (in_tuser_vendor),
        .out_tvalid       (out_tvalid),
        .out_tready       (out_tready),
        .out_tdata        (out_tdata),
        .out_tkeep        (out_tkeep),
        .out_tlast        (out_tlast),
        .out_tuser_vendor (out_tuser_vendor),
        .out_src_id       (out_src_id)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // source-side state: the beat each source currently presents
    bit                cur_vld  [NUM_SRC];
    bit                cur_sop  [NUM_SRC];
    bit                cur_last [NUM_SRC];
    logic [DATA_W-1:0] cur_data [NUM_SRC];
    logic [KEEP_W-1:0] cur_keep [NUM_SRC];
    logic [USER_W-1:0] cur_user [NUM_SRC];
    int                rem      [NUM_SRC];

    // stimulus knobs
    int                pv       = 8;     // chance out of 8 that an idle source asserts valid
    int                len_min  = 1;
    int                len_max  = 1;
    int                stall_n  = 0;     // chance out of 16 of out_tready=0
    bit [NUM_SRC-1:0]  sop_mask = '1;    // sources allowed to start new TLPs

    // reference model: TLP-level lock/pointer and the single output slot
    bit                m_locked = 1'b0;
    int                m_owner  = 0;
    int                m_rr     = 0;
    bit                e_vld    = 1'b0;
    logic [DATA_W-1:0] e_data   = '0;
    logic [KEEP_W-1:0] e_keep   = '0;
    bit                e_last   = 1'b0;
    logic [USER_W-1:0] e_user   = '0;
    int                e_src    = 0;
    int                tlp_done = 0;
    int                last_acc = -1;

    task automatic next_beat(input int i);
        logic [287:0] ut;
        if (rem[i] == 0) begin
            rem[i]     = $urandom_range(len_max, len_min);
            cur_sop[i] = 1'b1;
        end else begin
            cur_sop[i] = 1'b0;
        end
        rem[i]--;
        cur_last[i] = (rem[i] == 0);
        for (int w = 0; w < DATA_W / 32; w++) cur_data[i][w*32 +: 32] = $urandom;
        cur_keep[i] = {$urandom, $urandom};
        for (int w = 0; w < 9; w++) ut[w*32 +: 32] = $urandom;
        cur_user[i] = ut[USER_W-1:0];
        cur_vld[i]  = 1'b0;
    endtask

    task automatic reset_model();
        m_locked = 1'b0;
        m_owner  = 0;
        m_rr     = 0;
        e_vld    = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            rem[i] = 0;
            next_beat(i);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!cur_vld[i] && (!cur_sop[i] || sop_mask[i]))
                cur_vld[i] = ($urandom_range(8, 1) <= pv);
            in_tvalid[i]                      = cur_vld[i];
            in_tdata[i*DATA_W +: DATA_W]      = cur_data[i];
            in_tkeep[i*KEEP_W +: KEEP_W]      = cur_keep[i];
            in_tlast[i]                       = cur_last[i];
            in_tuser_vendor[i*USER_W +: USER_W] = cur_user[i];
        end
        out_tready = ($urandom_range(15, 0) >= stall_n);
    endtask

    // compare the DUT against the model for this cycle, then advance the model
    task automatic evaluate();
        int               exp_src;
        bit               adv;
        bit               prio_hit;
        logic [NUM_SRC-1:0] acc_vec;
        logic [NUM_SRC-1:0] exp_vec;

        chk("out_tvalid", out_tvalid, e_vld);
        if (e_vld) begin
            chk("out_tdata", out_tdata, e_data);
            chk("out_tkeep", out_tkeep, e_keep);
            chk("out_tlast", out_tlast, e_last);
            chk("out_tuser", out_tuser_vendor, e_user);
            chk("out_src_id", out_src_id, e_src);
            if (out_tready && e_last) tlp_done++;
        end

        adv      = !e_vld || out_tready;
        exp_src  = -1;
        prio_hit = 1'b0;
        if (adv) begin
            if (m_locked) begin
                if (cur_vld[m_owner]) exp_src = m_owner;
            end else begin
                if (PRIO_EN && cur_vld[0]) begin
                    exp_src  = 0;
                    prio_hit = 1'b1;
                end
                for (int k = 0; k < NUM_SRC; k++) begin
                    if (!prio_hit && exp_src < 0 && cur_vld[(m_rr + k) % NUM_SRC])
                        exp_src = (m_rr + k) % NUM_SRC;
                end
            end
        end

        exp_vec = '0;
        if (exp_src >= 0) exp_vec[exp_src] = 1'b1;
        acc_vec = in_tready & in_tvalid;
        chk("accept_vec", acc_vec, exp_vec);
        if (!adv) chk("tready_stalled", in_tready, '0);
        last_acc = -1;
        for (int i = 0; i < NUM_SRC; i++) if (acc_vec[i]) last_acc = i;

        if (adv) begin
            e_vld = (exp_src >= 0);
            if (e_vld) begin
                e_data = cur_data[exp_src];
                e_keep = cur_keep[exp_src];
                e_last = cur_last[exp_src];
                e_user = cur_user[exp_src];
                e_src  = exp_src;
            end
        end

        if (exp_src >= 0) begin
            if (cur_last[exp_src]) begin
                m_locked = 1'b0;
                if (!(PRIO_EN && exp_src == 0)) m_rr = (exp_src + 1) % NUM_SRC;
            end else begin
                m_locked = 1'b1;
                m_owner  = exp_src;
            end
            next_beat(exp_src);
        end
    endtask

    task automatic step();
        @(negedge clk);
        drive();
        #1;
        evaluate();
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) step();
    endtask

    task automatic knobs(input int p, input int lmin, input int lmax, input int st,
                         input bit [NUM_SRC-1:0] mask);
        pv       = p;
        len_min  = lmin;
        len_max  = lmax;
        stall_n  = st;
        sop_mask = mask;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tvalid"}, out_tvalid, 1'b0);
        chk({tag, "_tdata"}, out_tdata, '0);
        chk({tag, "_tkeep"}, out_tkeep, '0);
        chk({tag, "_tlast"}, out_tlast, 1'b0);
        chk({tag, "_tuser"}, out_tuser_vendor, '0);
        chk({tag, "_src_id"}, out_src_id, '0);
        chk({tag, "_in_tready"}, in_tready, '0);
    endtask

    initial begin
        int n;

        // power-on reset with every source already offering a beat
        knobs(8, 1, 1, 0, '1);
        reset_model();
        repeat (3) @(negedge clk);
        drive();
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;
        drive();
        #1;
        evaluate();
        chk("por_first_src", last_acc, 0);

        // 1-beat TLPs from all sources: 0,1,2,3,... at full rate
        run(40);

        // 5-beat TLPs from all sources with heavy backpressure
        knobs(8, 5, 5, 4, '1);
        run(300);

        // sparse valids: owner bubbles mid-TLP, idle gaps
        knobs(3, 1, 6, 2, '1);
        run(400);

        // reset while src3 is inside beat 2 of a 4-beat TLP
        knobs(8, 4, 4, 0, 4'b1000);
        n = 0;
        while (!(m_locked && m_owner == 3 && rem[3] == 1 && e_vld && e_src == 3) && n < 200) begin
            step();
            n++;
        end
        chk("reach_src3_beat2", n < 200, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        reset_model();
        knobs(8, 1, 4, 0, '1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive();
        #1;
        evaluate();
        chk("midrst_first_src", last_acc, 0);

        // long random run: 10000 TLPs, 1/16 output stall
        knobs(6, 1, 4, 1, '1);
        tlp_done = 0;
        n = 0;
        while (tlp_done < 10000 && n < 60000) begin
            step();
            n++;
        end
        chk("random_tlp_count", tlp_done >= 10000, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
